// File: rtl/asteroids_stage_ctrl_pkg.sv
// Shared game package: special-stage state encoding, default stage timing and the
// saturating bonus helper reused by every special stage controller.
package asteroids_stage_ctrl_pkg;

   typedef logic [2:0] stage_state_t;

   localparam stage_state_t StIdle  = 3'd0;
   localparam stage_state_t StClear = 3'd1;
   localparam stage_state_t StIntro = 3'd2;
   localparam stage_state_t StRun   = 3'd3;
   localparam stage_state_t StOutro = 3'd4;

   localparam int unsigned DEF_FRAMES_PER_SECOND = 60;
   localparam int unsigned DEF_INTRO_FRAMES      = 120;
   localparam int unsigned DEF_STAGE_SECONDS     = 30;
   localparam int unsigned DEF_OUTRO_FRAMES      = 90;
   localparam int unsigned DEF_BONUS_PER_SECOND  = 5;

   localparam int unsigned PHASE_CNT_W = 16;

   // Bonus is formed in 16 bits and clamped to the 8-bit score field.
   function automatic logic [7:0] sat_bonus(input logic [7:0] seconds,
                                            input logic [15:0] per_second);
      logic [15:0] product;
      product   = {8'd0, seconds} * per_second;
      sat_bonus = (product > 16'd255) ? 8'hff : product[7:0];
   endfunction

endpackage

// File: rtl/asteroids_stage_ctrl_frame_second_timer.sv
// frame_second_timer: divides startOfFrame pulses into game seconds, with load, pause and a
// one-cycle tick on the frame that completes each second.
module asteroids_stage_ctrl_frame_second_timer
   import asteroids_stage_ctrl_pkg::*;
#(
   parameter int unsigned FRAMES_PER_SECOND = DEF_FRAMES_PER_SECOND
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic enable,
   input  logic pause,
   input  logic start_of_frame,
   output logic sec_tick
);

   localparam int unsigned CNT_W = (FRAMES_PER_SECOND > 1) ? $clog2(FRAMES_PER_SECOND) : 1;
   localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(FRAMES_PER_SECOND - 1);

   logic [CNT_W-1:0] frame_q;
   logic             advance;

   assign advance  = enable & ~pause & start_of_frame;
   assign sec_tick = advance & (frame_q == LAST_FRAME);

   always_ff @(posedge clk) begin
      if (reset || load) begin
         frame_q <= '0;
      end else if (sec_tick) begin
         frame_q <= '0;
      end else if (advance) begin
         frame_q <= frame_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/asteroids_stage_ctrl.sv
// Special-stage sequencer: clears the asteroid field, shows the intro, runs the timed stage and
// reports win/loss with a time bonus before handing control back to the game flow.
module asteroids_stage_ctrl
   import asteroids_stage_ctrl_pkg::*;
#(
   parameter int unsigned FRAMES_PER_SECOND = DEF_FRAMES_PER_SECOND,
   parameter int unsigned INTRO_FRAMES      = DEF_INTRO_FRAMES,
   parameter int unsigned STAGE_SECONDS     = DEF_STAGE_SECONDS,
   parameter int unsigned OUTRO_FRAMES      = DEF_OUTRO_FRAMES,
   parameter int unsigned BONUS_PER_SECOND  = DEF_BONUS_PER_SECOND
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       startOfFrame,
   input  logic       stage_start,
   input  logic       pause,
   input  logic       all_asteroids_destroied,
   input  logic       player_hit,
   output logic       asteroids_resetN,
   output logic       asteroids_enable,
   output logic       intro_active,
   output logic [7:0] time_left,
   output logic       stage_won,
   output logic [7:0] bonus_points,
   output logic       stage_done
);

   localparam logic [PHASE_CNT_W-1:0] INTRO_LAST = PHASE_CNT_W'(INTRO_FRAMES - 1);
   localparam logic [PHASE_CNT_W-1:0] OUTRO_LAST = PHASE_CNT_W'(OUTRO_FRAMES - 1);
   localparam logic [7:0]             STAGE_TIME = 8'(STAGE_SECONDS);
   localparam logic [15:0]            BONUS_RATE = 16'(BONUS_PER_SECOND);

   stage_state_t           state_q, state_d;
   logic                   clear_hold_q, clear_hold_d;
   logic [PHASE_CNT_W-1:0] phase_cnt_q, phase_cnt_d;
   logic [7:0]             time_left_d, bonus_d;
   logic                   won_d, done_d;
   logic                   frame_adv, timer_load, timer_run, sec_tick;

   assign frame_adv = startOfFrame & ~pause;
   assign timer_run = (state_q == StRun);

   asteroids_stage_ctrl_frame_second_timer #(
      .FRAMES_PER_SECOND(FRAMES_PER_SECOND)
   ) u_frame_second_timer (
      .clk           (clk),
      .reset         (reset),
      .load          (timer_load),
      .enable        (timer_run),
      .pause         (pause),
      .start_of_frame(startOfFrame),
      .sec_tick      (sec_tick)
   );

   always_comb begin
      state_d      = state_q;
      clear_hold_d = 1'b0;
      phase_cnt_d  = phase_cnt_q;
      time_left_d  = time_left;
      won_d        = stage_won;
      bonus_d      = bonus_points;
      done_d       = 1'b0;
      timer_load   = 1'b0;
      case (state_q)
         StIdle: begin
            if (stage_start) begin
               state_d     = StClear;
               phase_cnt_d = '0;
               time_left_d = STAGE_TIME;
               won_d       = 1'b0;
               bonus_d     = '0;
               timer_load  = 1'b1;
            end
         end
         StClear: begin
            // Field re-arm lasts two cycles; the hold flag marks the second one.
            if (clear_hold_q) begin
               state_d = StIntro;
            end else begin
               clear_hold_d = 1'b1;
            end
         end
         StIntro: begin
            if (frame_adv) begin
               if (phase_cnt_q == INTRO_LAST) begin
                  state_d     = StRun;
                  phase_cnt_d = '0;
               end else begin
                  phase_cnt_d = phase_cnt_q + PHASE_CNT_W'(1);
               end
            end
         end
         StRun: begin
            // Win outranks loss, and an exit cycle never consumes a second.
            if (all_asteroids_destroied) begin
               state_d = StOutro;
               won_d   = 1'b1;
               bonus_d = sat_bonus(time_left, BONUS_RATE);
            end else if (player_hit) begin
               state_d = StOutro;
               won_d   = 1'b0;
               bonus_d = '0;
            end else if (sec_tick && (time_left != 8'd0)) begin
               time_left_d = time_left - 8'd1;
               if (time_left == 8'd1) begin
                  state_d = StOutro;
                  won_d   = 1'b0;
                  bonus_d = '0;
               end
            end
         end
         StOutro: begin
            if (frame_adv) begin
               if (phase_cnt_q == OUTRO_LAST) begin
                  state_d     = StIdle;
                  phase_cnt_d = '0;
                  done_d      = 1'b1;
               end else begin
                  phase_cnt_d = phase_cnt_q + PHASE_CNT_W'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= StIdle;
         clear_hold_q     <= 1'b0;
         phase_cnt_q      <= '0;
         asteroids_resetN <= 1'b1;
         asteroids_enable <= 1'b0;
         intro_active     <= 1'b0;
         time_left        <= '0;
         stage_won        <= 1'b0;
         bonus_points     <= '0;
         stage_done       <= 1'b0;
      end else begin
         state_q          <= state_d;
         clear_hold_q     <= clear_hold_d;
         phase_cnt_q      <= phase_cnt_d;
         asteroids_resetN <= (state_d != StClear);
         asteroids_enable <= (state_d == StRun) && !pause;
         intro_active     <= (state_d == StIntro);
         time_left        <= time_left_d;
         stage_won        <= won_d;
         bonus_points     <= bonus_d;
         stage_done       <= done_d;
      end
   end

endmodule

// File: tb/tb_asteroids_stage_ctrl.sv
// Bench for asteroids_stage_ctrl: directed stage scenarios plus randomized play on two
// instances (30 s and 200 s stages), checked every cycle against a frame-count model.
`timescale 1ns/1ps
module tb_asteroids_stage_ctrl;

   localparam int FPS   = 60;
   localparam int INTRO = 120;
   localparam int OUTRO = 90;
   localparam int BPS   = 5;

   localparam int P_IDLE  = 0;
   localparam int P_CLEAR = 1;
   localparam int P_INTRO = 2;
   localparam int P_RUN   = 3;
   localparam int P_OUTRO = 4;

   logic       clk = 1'b0;
   logic       reset, sof, pause;
   logic       stim_start[2], stim_dest[2], stim_hit[2];
   logic       obs_rn[2], obs_en[2], obs_intro[2], obs_won[2], obs_done[2];
   logic [7:0] obs_tl[2], obs_bonus[2];

   int checks = 0;
   int errors = 0;
   int cmp_errors = 0;
   int adv_cnt = 0;
   int sof_cnt = 0;
   int gap = 0;
   bit check_on = 1'b0;

   // Model state: phase plus frame counts; remaining time is derived from frames played.
   int stage_len[2] = '{30, 200};
   int ph[2], clr[2], frm[2], run_frm[2], m_tl[2], m_bonus[2];
   bit m_won[2], m_done[2], m_rn[2], m_en[2], m_intro[2];

   always #5 clk = ~clk;

   asteroids_stage_ctrl #(
      .FRAMES_PER_SECOND(FPS),
      .INTRO_FRAMES     (INTRO),
      .STAGE_SECONDS    (30),
      .OUTRO_FRAMES     (OUTRO),
      .BONUS_PER_SECOND (BPS)
   ) dut_std (
      .clk                    (clk),
      .reset                  (reset),
      .startOfFrame           (sof),
      .stage_start            (stim_start[0]),
      .pause                  (pause),
      .all_asteroids_destroied(stim_dest[0]),
      .player_hit             (stim_hit[0]),
      .asteroids_resetN       (obs_rn[0]),
      .asteroids_enable       (obs_en[0]),
      .intro_active           (obs_intro[0]),
      .time_left              (obs_tl[0]),
      .stage_won              (obs_won[0]),
      .bonus_points           (obs_bonus[0]),
      .stage_done             (obs_done[0])
   );

   asteroids_stage_ctrl #(
      .FRAMES_PER_SECOND(FPS),
      .INTRO_FRAMES     (INTRO),
      .STAGE_SECONDS    (200),
      .OUTRO_FRAMES     (OUTRO),
      .BONUS_PER_SECOND (BPS)
   ) dut_long (
      .clk                    (clk),
      .reset                  (reset),
      .startOfFrame           (sof),
      .stage_start            (stim_start[1]),
      .pause                  (pause),
      .all_asteroids_destroied(stim_dest[1]),
      .player_hit             (stim_hit[1]),
      .asteroids_resetN       (obs_rn[1]),
      .asteroids_enable       (obs_en[1]),
      .intro_active           (obs_intro[1]),
      .time_left              (obs_tl[1]),
      .stage_won              (obs_won[1]),
      .bonus_points           (obs_bonus[1]),
      .stage_done             (obs_done[1])
   );

   task automatic model_step(input int k);
      bit adv;
      int raw;
      adv       = sof && !pause;
      m_done[k] = 1'b0;
      if (reset) begin
         ph[k] = P_IDLE; clr[k] = 0; frm[k] = 0; run_frm[k] = 0;
         m_tl[k] = 0; m_won[k] = 1'b0; m_bonus[k] = 0;
      end else begin
         case (ph[k])
            P_IDLE: if (stim_start[k]) begin
               ph[k] = P_CLEAR; clr[k] = 0; frm[k] = 0; run_frm[k] = 0;
               m_tl[k] = stage_len[k]; m_won[k] = 1'b0; m_bonus[k] = 0;
            end
            P_CLEAR: begin
               clr[k]++;
               if (clr[k] == 2) ph[k] = P_INTRO;
            end
            P_INTRO: if (adv) begin
               frm[k]++;
               if (frm[k] == INTRO) begin ph[k] = P_RUN; frm[k] = 0; end
            end
            P_RUN: begin
               if (stim_dest[k]) begin
                  raw = m_tl[k] * BPS;
                  ph[k] = P_OUTRO; frm[k] = 0; m_won[k] = 1'b1;
                  m_bonus[k] = (raw > 255) ? 255 : raw;
               end else if (stim_hit[k]) begin
                  ph[k] = P_OUTRO; frm[k] = 0; m_won[k] = 1'b0; m_bonus[k] = 0;
               end else if (adv) begin
                  run_frm[k]++;
                  m_tl[k] = stage_len[k] - run_frm[k] / FPS;
                  if (m_tl[k] == 0) begin ph[k] = P_OUTRO; frm[k] = 0; end
               end
            end
            P_OUTRO: if (adv) begin
               frm[k]++;
               if (frm[k] == OUTRO) begin ph[k] = P_IDLE; m_done[k] = 1'b1; end
            end
            default: ph[k] = P_IDLE;
         endcase
      end
      m_rn[k]    = (ph[k] != P_CLEAR);
      m_en[k]    = (ph[k] == P_RUN) && !pause;
      m_intro[k] = (ph[k] == P_INTRO);
   endtask

   task automatic compare_outputs(input int k);
      logic [20:0] got, want;
      got  = {obs_rn[k], obs_en[k], obs_intro[k], obs_won[k], obs_done[k], obs_tl[k],
              obs_bonus[k]};
      want = {m_rn[k], m_en[k], m_intro[k], m_won[k], m_done[k], 8'(m_tl[k]), 8'(m_bonus[k])};
      checks++;
      if (got !== want) begin
         errors++;
         cmp_errors++;
         $display("FAIL model_cmp dut%0d t=%0t: got rn=%b en=%b intro=%b won=%b done=%b tl=%0d bonus=%0d, expected rn=%b en=%b intro=%b won=%b done=%b tl=%0d bonus=%0d",
                  k, $time, obs_rn[k], obs_en[k], obs_intro[k], obs_won[k], obs_done[k],
                  obs_tl[k], obs_bonus[k], m_rn[k], m_en[k], m_intro[k], m_won[k], m_done[k],
                  m_tl[k], m_bonus[k]);
      end
   endtask

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      if (sof) sof_cnt++;
      if (sof && !pause) adv_cnt++;
      #1;
      if (sof) begin
         sof = 1'b0;
         gap = int'($urandom_range(1, 0));
      end else if (gap > 0) begin
         gap--;
      end else begin
         sof = 1'b1;
      end
   endtask

   task automatic pulse_start(input int k);
      stim_start[k] = 1'b1;
      next_cycle();
      stim_start[k] = 1'b0;
   endtask

   task automatic wait_tl(input int k, input int value, input int budget, input string name);
      int n;
      n = 0;
      while (int'(obs_tl[k]) != value && n < budget) begin next_cycle(); n++; end
      check(name, int'(obs_tl[k]), value);
   endtask

   task automatic wait_done(input int k, input int budget, input string name);
      int n;
      n = 0;
      while (obs_done[k] !== 1'b1 && n < budget) begin next_cycle(); n++; end
      check(name, int'(obs_done[k]), 1);
   endtask

   task automatic check_reset_values(input int k);
      check("rst_resetN", int'(obs_rn[k]), 1);
      check("rst_enable", int'(obs_en[k]), 0);
      check("rst_intro", int'(obs_intro[k]), 0);
      check("rst_time_left", int'(obs_tl[k]), 0);
      check("rst_won", int'(obs_won[k]), 0);
      check("rst_bonus", int'(obs_bonus[k]), 0);
      check("rst_done", int'(obs_done[k]), 0);
   endtask

   initial forever begin
      @(posedge clk);
      model_step(0);
      model_step(1);
   end

   initial forever begin
      @(negedge clk);
      if (check_on && cmp_errors < 100) begin
         for (int k = 0; k < 2; k++) compare_outputs(k);
      end
   end

   initial begin
      int low_cnt, f_intro, f_run, f_out, f_done, s0, n;
      reset = 1'b1;
      sof   = 1'b0;
      pause = 1'b0;
      for (int k = 0; k < 2; k++) begin
         stim_start[k] = 1'b1;
         stim_dest[k]  = 1'b0;
         stim_hit[k]   = 1'b0;
      end
      repeat (3) next_cycle();
      check_on = 1'b1;
      reset = 1'b0;
      stim_start[0] = 1'b0;
      stim_start[1] = 1'b0;
      next_cycle();
      check_reset_values(0);
      check_reset_values(1);

      // Full timed-out stage with default timing.
      pulse_start(0);
      low_cnt = 0;
      while (obs_rn[0] == 1'b0 && low_cnt < 10) begin low_cnt++; next_cycle(); end
      check("clear_cycles", low_cnt, 2);
      f_intro = adv_cnt;
      check("intro_on", int'(obs_intro[0]), 1);
      n = 0;
      while (obs_intro[0] == 1'b1 && n < 1000) begin next_cycle(); n++; end
      f_run = adv_cnt;
      check("intro_frames", f_run - f_intro, INTRO);
      check("tl_at_run", int'(obs_tl[0]), 30);
      check("enable_at_run", int'(obs_en[0]), 1);
      wait_tl(0, 0, 8000, "timeout_tl");
      f_out = adv_cnt;
      check("run_frames", f_out - f_run, 1800);
      check("timeout_won", int'(obs_won[0]), 0);
      check("timeout_enable", int'(obs_en[0]), 0);
      wait_done(0, 1000, "timeout_done");
      f_done = adv_cnt;
      check("outro_frames", f_done - f_out, OUTRO);
      check("done_tl", int'(obs_tl[0]), 0);
      next_cycle();
      check("done_width", int'(obs_done[0]), 0);

      // Win at 12 s left; stage_start during outro must be ignored.
      pulse_start(0);
      wait_tl(0, 12, 10000, "reach_tl12");
      stim_dest[0] = 1'b1;
      next_cycle();
      stim_dest[0] = 1'b0;
      check("win12_won", int'(obs_won[0]), 1);
      check("win12_bonus", int'(obs_bonus[0]), 60);
      check("model_win12_bonus", m_bonus[0], 60);
      repeat (20) next_cycle();
      check("win12_tl_hold", int'(obs_tl[0]), 12);
      pulse_start(0);
      wait_done(0, 1000, "win12_done");
      check("win12_bonus_held", int'(obs_bonus[0]), 60);
      repeat (4) next_cycle();
      check("outro_start_ignored_rn", int'(obs_rn[0]), 1);
      check("outro_start_ignored_intro", int'(obs_intro[0]), 0);

      // 200 s stage won at 100 s left: bonus saturates.
      pulse_start(1);
      wait_tl(1, 100, 25000, "reach_tl100");
      stim_dest[1] = 1'b1;
      next_cycle();
      stim_dest[1] = 1'b0;
      check("sat_won", int'(obs_won[1]), 1);
      check("sat_bonus", int'(obs_bonus[1]), 255);
      check("model_sat_bonus", m_bonus[1], 255);
      wait_done(1, 1000, "sat_done");

      // Hit and win in the same cycle: win has priority.
      pulse_start(0);
      wait_tl(0, 5, 10000, "reach_tl5");
      stim_dest[0] = 1'b1;
      stim_hit[0]  = 1'b1;
      next_cycle();
      stim_dest[0] = 1'b0;
      stim_hit[0]  = 1'b0;
      check("tie_won", int'(obs_won[0]), 1);
      check("tie_bonus", int'(obs_bonus[0]), 25);
      check("tie_tl", int'(obs_tl[0]), 5);
      wait_done(0, 1000, "tie_done");

      // Pause for 300 frames at 20 s, then reset mid-run at 7 s.
      pulse_start(0);
      wait_tl(0, 20, 10000, "reach_tl20");
      pause = 1'b1;
      s0 = sof_cnt;
      n = 0;
      while (sof_cnt - s0 < 300 && n < 2000) begin next_cycle(); n++; end
      check("pause_frames", sof_cnt - s0, 300);
      check("pause_tl", int'(obs_tl[0]), 20);
      check("pause_enable", int'(obs_en[0]), 0);
      pause = 1'b0;
      next_cycle();
      check("resume_enable", int'(obs_en[0]), 1);
      wait_tl(0, 19, 400, "resume_tl19");
      wait_tl(0, 7, 5000, "reach_tl7");
      reset = 1'b1;
      next_cycle();
      check_reset_values(0);
      reset = 1'b0;

      // Randomized play on both instances.
      for (int it = 0; it < 6; it++) begin
         stim_start[0] = 1'b1;
         stim_start[1] = 1'b1;
         next_cycle();
         for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(15, 0) == 0) pause = ~pause;
            reset = ($urandom_range(2999, 0) == 0);
            for (int k = 0; k < 2; k++) begin
               stim_start[k] = ($urandom_range(199, 0) == 0);
               stim_dest[k]  = ($urandom_range(499, 0) == 0);
               stim_hit[k]   = ($urandom_range(699, 0) == 0);
            end
            next_cycle();
         end
      end
      reset = 1'b0;
      pause = 1'b0;
      for (int k = 0; k < 2; k++) begin
         stim_start[k] = 1'b0;
         stim_dest[k]  = 1'b0;
         stim_hit[k]   = 1'b0;
      end
      repeat (4) next_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/asteroids_stage_ctrl.md
ASTEROIDS_STAGE_CTRL -- requirements
Module: asteroids_stage_ctrl

Interface
REQ-001 SHALL have parameter FRAMES_PER_SECOND, default 60, meaning startOfFrame pulses per game second.
REQ-002 SHALL have parameter INTRO_FRAMES, default 120, meaning frames of intro before asteroids move.
REQ-003 SHALL have parameter STAGE_SECONDS, default 30, meaning run-phase time limit in seconds (1..255).
REQ-004 SHALL have parameter OUTRO_FRAMES, default 90, meaning frames shown after win/loss before completion.
REQ-005 SHALL have parameter BONUS_PER_SECOND, default 5, meaning bonus points per remaining second.
REQ-006 SHALL have ports: clk  in  1  system clock; reset  in  1  synchronous active-high reset.
REQ-007 SHALL have ports: startOfFrame  in  1  one-cycle frame pulse; stage_start  in  1  one-cycle request from game flow; pause  in  1  level, freezes stage.
REQ-008 SHALL have ports: all_asteroids_destroied  in  1  level from asteroid field; player_hit  in  1  player/asteroid collision pulse.
REQ-009 SHALL have ports: asteroids_resetN  out  1  active-low re-arm of asteroid field; asteroids_enable  out  1  motion enable; intro_active  out  1  intro banner request.
REQ-010 SHALL have ports: time_left  out  8  remaining seconds; stage_won  out  1  result; bonus_points  out  8  bonus; stage_done  out  1  one-cycle completion pulse.

Function
REQ-011 SHALL implement FSM states IDLE, CLEAR, INTRO, RUN, OUTRO; all outputs registered.
REQ-012 IDLE: stage_start=1 -> CLEAR; stage_start in any other state SHALL be ignored.
REQ-013 CLEAR: asteroids_resetN=0 for exactly 2 clk cycles, then INTRO; time_left loaded with STAGE_SECONDS, stage_won=0, bonus_points=0, frame counter=0.
REQ-014 INTRO: intro_active=1; counts startOfFrame pulses; on the INTRO_FRAMES-th pulse -> RUN, intro_active=0 next cycle.
REQ-015 RUN: asteroids_enable=1 while pause=0; frame counter increments per startOfFrame, wraps at FRAMES_PER_SECOND-1 and decrements time_left by 1.
REQ-016 RUN exit, win: all_asteroids_destroied=1 -> OUTRO, stage_won=1, bonus_points=min(255, time_left*BONUS_PER_SECOND), computed in 16 bits then saturated.
REQ-017 RUN exit, loss: player_hit=1, or time_left decrements to 0 -> OUTRO, stage_won=0, bonus_points=0.
REQ-018 Simultaneous win and loss condition in the same cycle: win SHALL take priority; time_left SHALL NOT decrement in the exit cycle.
REQ-019 time_left SHALL never wrap below 0; at 0 it holds.
REQ-020 pause=1 SHALL freeze all frame counters and time_left in INTRO, RUN, OUTRO and force asteroids_enable=0; state transitions on player_hit/all_asteroids_destroied still evaluated in RUN.
REQ-021 OUTRO: asteroids_enable=0; after OUTRO_FRAMES startOfFrame pulses -> IDLE with stage_done=1 for exactly one clk; stage_won, bonus_points, time_left held until next CLEAR.
REQ-022 asteroids_resetN SHALL be 1 in all states except CLEAR.

Reset
REQ-023 reset=1 at a clk edge SHALL force IDLE from any state, mid-operation included.
REQ-024 Reset values: asteroids_resetN=1, asteroids_enable=0, intro_active=0, time_left=0, stage_won=0, bonus_points=0, stage_done=0, counters=0.
REQ-025 A stage_start coincident with reset SHALL be ignored.

Structure
REQ-026 State enum typedef and default timing constants SHALL live in the shared game package, reused by other special stages.
REQ-027 One sub-module, frame_second_timer (startOfFrame divider with load, pause, wrap pulse), SHALL be used for the RUN seconds count.
REQ-028 Implementation SHALL be 120-400 lines RTL, no multi-cycle paths.

Verification
REQ-029 stage_start, no hits, defaults -> resetN low 2 cycles, intro 120 frames, time_left 30->0 over 1800 frames, stage_won=0, stage_done pulse after 90 more frames.
REQ-030 all_asteroids_destroied at time_left=12 -> OUTRO, stage_won=1, bonus_points=60; time_left holds 12.
REQ-031 STAGE_SECONDS=200, win at time_left=100 -> bonus_points=255 (saturated).
REQ-032 player_hit and all_asteroids_destroied same cycle at time_left=5 -> stage_won=1, bonus_points=25.
REQ-033 pause=1 for 300 frames in RUN at time_left=20 -> time_left stays 20, asteroids_enable=0; resumes decrementing after release.
REQ-034 reset asserted in RUN at time_left=7 -> next cycle IDLE, all outputs at reset values; stage_start during OUTRO ignored.
